flex_counter: RTL and testbench

Parametrised up/down counter with programmable lower and upper bounds, step size, parallel load, and a selectable wrap or saturate mode. It also produces a registered rollover pulse. It is the general-purpose successor to the team's basic single-direction counter, and is meant for timers, address walkers and baud/tick generators throughout the design. An optional prescaler divides the enable rate.

---
 rtl/flex_counter_pkg.sv | 18 +
 rtl/flex_prescaler.sv | 32 +++
 rtl/flex_counter.sv | 112 +++++++++++
 tb/tb_flex_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types and default widths for the flex_counter block.
// The optional prescaler is selected with the FLEX_COUNTER_PRESCALE_EN macro.
package flex_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_N          = 8;
  localparam int unsigned DEFAULT_PRESCALE_W = 8;

endpackage

// File: rtl/flex_prescaler.sv
// Enable-rate divider: tick is high on the enabled cycle where the count reaches prescale.
// Used by flex_counter only when FLEX_COUNTER_PRESCALE_EN is defined.
module flex_prescaler
  import flex_counter_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = (pcnt == prescale);

  // restart (clear/load) wins over counting; enable low freezes the count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pcnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
    end else if (enable) begin
      if (tick) pcnt <= '0;
      else      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/flex_counter.sv
// Up/down counter with programmable bounds, step, load, wrap/saturate and a rollover pulse.
// Defining FLEX_COUNTER_PRESCALE_EN adds the prescale port and the flex_prescaler divider.
module flex_counter
  import flex_counter_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [N-1:0]          load_val,
  input  logic                  dir,
  input  logic                  mode,
  input  logic [N-1:0]          step,
  input  logic [N-1:0]          min,
  input  logic [N-1:0]          max,
`ifdef FLEX_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [N-1:0]          count,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  rollover
);

  if (N < 2 || PRESCALE_W < 1) begin : g_param_check
    $error("flex_counter: N must be at least 2 and PRESCALE_W at least 1");
  end

  logic         tick;
  logic         advance;
  logic         cfg_ok;
  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] count_nxt;
  logic         wrap_nxt;

`ifdef FLEX_COUNTER_PRESCALE_EN
  flex_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .restart  (clear | load),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign advance = enable & tick;
  assign cfg_ok  = (min <= max);
  assign sum     = {1'b0, count} + {1'b0, step};
  assign diff    = {1'b0, count} - {1'b0, step};

  assign at_max  = (count == max);
  assign at_min  = (count == min);

  // Next value of an advance; a zero step or an inverted range holds the count
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (advance && cfg_ok && (step != '0)) begin
      if (dir_e'(dir) == DIR_UP) begin
        if (sum > {1'b0, max}) begin
          if (mode_e'(mode) == MODE_WRAP) begin
            count_nxt = min;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = max;
          end
        end else begin
          count_nxt = sum[N-1:0];
        end
      end else begin
        // diff[N] is the borrow out of the subtraction
        if (diff[N] || (diff[N-1:0] < min)) begin
          if (mode_e'(mode) == MODE_WRAP) begin
            count_nxt = max;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = min;
          end
        end else begin
          count_nxt = diff[N-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count    <= '0;
      rollover <= 1'b0;
    end else if (clear) begin
      count    <= min;
      rollover <= 1'b0;
    end else if (load) begin
      count    <= load_val;
      rollover <= 1'b0;
    end else begin
      count    <= count_nxt;
      rollover <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_flex_counter.sv
// Directed test-plan cases plus randomized traffic against an integer reference model.
// Also exercises the prescaler when FLEX_COUNTER_PRESCALE_EN is defined.
module tb_flex_counter;

  localparam int N  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  load_val = '0;
  logic          dir = 1'b1;
  logic          mode = 1'b1;
  logic [N-1:0]  step = 4'd1;
  logic [N-1:0]  min = '0;
  logic [N-1:0]  max = 4'd15;
  logic [PW-1:0] prescale = '0;
  logic [N-1:0]  count;
  logic          at_max;
  logic          at_min;
  logic          rollover;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_count = 0;
  int m_roll  = 0;
  int m_pcnt  = 0;

  flex_counter #(
    .N          (N),
    .PRESCALE_W (PW)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .step     (step),
    .min      (min),
    .max      (max),
`ifdef FLEX_COUNTER_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .at_max   (at_max),
    .at_min   (at_min),
    .rollover (rollover)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of the reference behaviour using plain integer arithmetic
  function automatic void model_step();
    int lo, hi, st, nv;
    bit adv;
    lo = int'(min);
    hi = int'(max);
    st = int'(step);
    m_roll = 0;
    if (clear) begin
      m_count = lo;
      m_pcnt  = 0;
    end else if (load) begin
      m_count = int'(load_val);
      m_pcnt  = 0;
    end else if (enable) begin
      adv = 1'b1;
`ifdef FLEX_COUNTER_PRESCALE_EN
      adv = (m_pcnt == int'(prescale));
      m_pcnt = adv ? 0 : (m_pcnt + 1) % (1 << PW);
`endif
      if (adv && st != 0 && lo <= hi) begin
        if (dir) begin
          nv = m_count + st;
          if (nv > hi) begin
            m_count = mode ? lo : hi;
            m_roll  = mode ? 1 : 0;
          end else begin
            m_count = nv;
          end
        end else begin
          nv = m_count - st;
          if (nv < lo) begin
            m_count = mode ? hi : lo;
            m_roll  = mode ? 1 : 0;
          end else begin
            m_count = nv;
          end
        end
      end
    end
  endfunction

  // Advance one clock and compare every output with the model
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".count"},    int'(count),    m_count);
    check({tag, ".rollover"}, int'(rollover), m_roll);
    check({tag, ".at_max"},   int'(at_max),   int'(m_count == int'(max)));
    check({tag, ".at_min"},   int'(at_min),   int'(m_count == int'(min)));
  endtask

  task automatic set_cfg(input logic d, input logic m, input int st, input int lo, input int hi);
    dir  = d;
    mode = m;
    step = st[N-1:0];
    min  = lo[N-1:0];
    max  = hi[N-1:0];
  endtask

  task automatic ctl(input logic en, input logic clr, input logic ld, input int lv);
    enable   = en;
    clear    = clr;
    load     = ld;
    load_val = lv[N-1:0];
  endtask

  initial begin
    // reset state
    #2;
    check("reset.count", int'(count), 0);
    check("reset.rollover", int'(rollover), 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // up, wrap within [2,5]
    set_cfg(1'b1, 1'b1, 1, 2, 5);
    ctl(1'b0, 1'b1, 1'b0, 0);
    tick("wrap_clr");
    check("wrap_clr.lit", int'(count), 2);
    ctl(1'b1, 1'b0, 1'b0, 0);
    tick("wrap_e1"); check("wrap_e1.lit", int'(count), 3);
    tick("wrap_e2"); check("wrap_e2.lit", int'(count), 4);
    tick("wrap_e3"); check("wrap_e3.lit", int'(count), 5);
    check("wrap_e3.at_max_lit", int'(at_max), 1);
    tick("wrap_e4"); check("wrap_e4.lit", int'(count), 2);
    check("wrap_e4.roll_lit", int'(rollover), 1);
    ctl(1'b0, 1'b0, 1'b0, 0);
    tick("wrap_hold");
    check("wrap_hold.roll_lit", int'(rollover), 0);

    // down, saturate at min=3 from 7 with step 3
    set_cfg(1'b0, 1'b0, 3, 3, 15);
    ctl(1'b0, 1'b0, 1'b1, 7);
    tick("sat_load");
    ctl(1'b1, 1'b0, 1'b0, 0);
    tick("sat_e1"); check("sat_e1.lit", int'(count), 4);
    tick("sat_e2"); check("sat_e2.lit", int'(count), 3);
    check("sat_e2.at_min_lit", int'(at_min), 1);
    tick("sat_e3"); check("sat_e3.lit", int'(count), 3);
    check("sat_e3.roll_lit", int'(rollover), 0);

    // carry out of the N-bit sum
    set_cfg(1'b1, 1'b1, 5, 0, 15);
    ctl(1'b0, 1'b0, 1'b1, 14);
    tick("carry_load");
    ctl(1'b1, 1'b0, 1'b0, 0);
    tick("carry_wrap");
    check("carry_wrap.lit", int'(count), 0);
    check("carry_wrap.roll_lit", int'(rollover), 1);
    mode = 1'b0;
    ctl(1'b0, 1'b0, 1'b1, 14);
    tick("carry_load2");
    ctl(1'b1, 1'b0, 1'b0, 0);
    tick("carry_sat");
    check("carry_sat.lit", int'(count), 15);

    // priority clear > load > advance
    set_cfg(1'b1, 1'b1, 1, 2, 12);
    ctl(1'b1, 1'b1, 1'b1, 9);
    tick("prio_clr");
    check("prio_clr.lit", int'(count), 2);
    ctl(1'b1, 1'b0, 1'b1, 9);
    tick("prio_load");
    check("prio_load.lit", int'(count), 9);

    // asynchronous reset between edges
    set_cfg(1'b1, 1'b1, 1, 0, 15);
    ctl(1'b0, 1'b0, 1'b1, 5);
    tick("rst_load");
    ctl(1'b1, 1'b0, 1'b0, 0);
    tick("rst_count6");
    check("rst_count6.lit", int'(count), 6);
    #3 nrst = 1'b0;
    #1;
    check("rst_async.count", int'(count), 0);
    check("rst_async.rollover", int'(rollover), 0);
    #1 nrst = 1'b1;
    m_count = 0;
    m_roll  = 0;
    m_pcnt  = 0;
    tick("rst_resume");
    check("rst_resume.lit", int'(count), 1);

`ifdef FLEX_COUNTER_PRESCALE_EN
    // divide by 3, then a 2-cycle enable gap
    prescale = 8'd2;
    ctl(1'b0, 1'b1, 1'b0, 0);
    tick("pre_clr");
    ctl(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) tick("pre_run");
    check("pre_run.lit", int'(count), 2);
    ctl(1'b0, 1'b0, 1'b0, 0);
    tick("pre_gap1");
    tick("pre_gap2");
    ctl(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) tick("pre_resume");
    check("pre_resume.lit", int'(count), 3);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
              int'($urandom_range(4, 15)));
      ctl(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)));
      prescale = PW'($urandom_range(0, 2));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
